// File: rtl/axi_slave_mem_if.sv
// AXI4 burst channel bundle (AW/W/B/AR/R) between a master model and axi_slave_mem.
interface axi_slave_mem_if #(
    parameter int DATA_W = 1024
);
    logic [63:0]       AWADDR;
    logic [7:0]        AWLEN;
    logic              AWVALID;
    logic              AWREADY;
    logic [DATA_W-1:0] WDATA;
    logic              WLAST;
    logic              WVALID;
    logic              WREADY;
    logic [1:0]        BRESP;
    logic              BVALID;
    logic              BREADY;
    logic [63:0]       ARADDR;
    logic [7:0]        ARLEN;
    logic              ARVALID;
    logic              ARREADY;
    logic [DATA_W-1:0] RDATA;
    logic              RLAST;
    logic              RVALID;
    logic              RREADY;

    modport master (
        output AWADDR, AWLEN, AWVALID, WDATA, WLAST, WVALID, BREADY,
        output ARADDR, ARLEN, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RLAST, RVALID
    );

    modport slave (
        input  AWADDR, AWLEN, AWVALID, WDATA, WLAST, WVALID, BREADY,
        input  ARADDR, ARLEN, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RLAST, RVALID
    );
endinterface

// File: rtl/axi_slave_mem.sv
// AXI4 memory responder: W-to-B 1 cycle, AR-to-R 1 cycle, one beat/cycle, outputs hold under backpressure.
// `define AXI_SLV_BACKPRESSURE_EN to throttle WREADY and insert a gap between R beats.
module axi_slave_mem #(
    parameter int DATA_W = 1024,
    parameter int DEPTH  = 256,
    parameter int TCO    = 1
) (
    input  logic            ACLK,
    input  logic            ARESETn,
    axi_slave_mem_if.slave  s_axi
);
    localparam int LSB = $clog2(DATA_W / 8);
    localparam int IW  = $clog2(DEPTH);

    typedef logic [IW-1:0] idx_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    if (DATA_W < 8 || (DATA_W & (DATA_W - 1)) != 0 || DEPTH < 2 ||
        (DEPTH & (DEPTH - 1)) != 0 || TCO < 0) begin : g_bad_cfg
        $error("axi_slave_mem: illegal parameter set");
    end

    logic [DATA_W-1:0] mem [DEPTH];

    // Only the word-index slice of each address is used.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{s_axi.AWADDR, s_axi.ARADDR};

    w_state_t w_state_q, w_state_d;
    idx_t     w_idx_q, w_idx_d;
    logic [7:0] w_len_q, w_len_d, w_cnt_q, w_cnt_d;
    logic     w_err_q, w_err_d;
    logic     awready_q, awready_d;
    logic     wready, w_at_len, mem_we;

`ifdef AXI_SLV_BACKPRESSURE_EN
    logic w_tog_q;
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn)                  w_tog_q <= 1'b0;
        else if (w_state_q != W_DATA)  w_tog_q <= 1'b0;
        else                           w_tog_q <= ~w_tog_q;
    end
    assign wready = (w_state_q == W_DATA) && w_tog_q;
`else
    assign wready = (w_state_q == W_DATA);
`endif

    always_comb begin
        w_state_d = w_state_q;
        w_idx_d   = w_idx_q;
        w_len_d   = w_len_q;
        w_cnt_d   = w_cnt_q;
        w_err_d   = w_err_q;
        mem_we    = 1'b0;
        w_at_len  = (w_cnt_q == w_len_q);
        case (w_state_q)
            W_IDLE: if (s_axi.AWVALID && awready_q) begin
                w_idx_d   = s_axi.AWADDR[LSB +: IW];
                w_len_d   = s_axi.AWLEN;
                w_cnt_d   = 8'd0;
                w_err_d   = 1'b0;
                w_state_d = W_DATA;
            end
            W_DATA: if (s_axi.WVALID && wready) begin
                mem_we  = 1'b1;
                w_idx_d = w_idx_q + 1'b1;
                w_cnt_d = w_cnt_q + 8'd1;
                // Burst closes on whichever marker comes first; disagreement is an error.
                if (s_axi.WLAST || w_at_len) begin
                    w_err_d   = s_axi.WLAST ^ w_at_len;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: if (s_axi.BREADY) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
        awready_d = (w_state_d == W_IDLE);
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state_q <= W_IDLE;
            w_idx_q   <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_err_q   <= 1'b0;
            awready_q <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            w_idx_q   <= w_idx_d;
            w_len_q   <= w_len_d;
            w_cnt_q   <= w_cnt_d;
            w_err_q   <= w_err_d;
            awready_q <= awready_d;
        end
    end

    always_ff @(posedge ACLK) begin
        if (mem_we) mem[w_idx_q] <= s_axi.WDATA;
    end

    assign s_axi.AWREADY = awready_q;
    assign s_axi.WREADY  = wready;
    assign s_axi.BVALID  = (w_state_q == W_RESP);
    assign s_axi.BRESP   = ((w_state_q == W_RESP) && w_err_q) ? 2'b10 : 2'b00;

    r_state_t r_state_q, r_state_d;
    idx_t     r_idx_q, r_idx_d, r_idx_inc;
    logic [7:0] r_len_q, r_len_d, r_cnt_q, r_cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic     rvalid_q, rvalid_d;
    logic     arready_q, arready_d;
    logic     rlast;

    assign rlast     = rvalid_q && (r_state_q == R_DATA) && (r_cnt_q == r_len_q);
    assign r_idx_inc = r_idx_q + 1'b1;

    always_comb begin
        r_state_d = r_state_q;
        r_idx_d   = r_idx_q;
        r_len_d   = r_len_q;
        r_cnt_d   = r_cnt_q;
        rdata_d   = rdata_q;
        rvalid_d  = rvalid_q;
        case (r_state_q)
            R_IDLE: if (s_axi.ARVALID && arready_q) begin
                r_idx_d   = s_axi.ARADDR[LSB +: IW];
                r_len_d   = s_axi.ARLEN;
                r_cnt_d   = 8'd0;
                rdata_d   = mem[s_axi.ARADDR[LSB +: IW]];
                rvalid_d  = 1'b1;
                r_state_d = R_DATA;
            end
            R_DATA: begin
                if (!rvalid_q) begin
                    // Refill after an inserted gap; index already advanced.
                    rdata_d  = mem[r_idx_q];
                    rvalid_d = 1'b1;
                end else if (s_axi.RREADY) begin
                    if (rlast) begin
                        rvalid_d  = 1'b0;
                        r_state_d = R_IDLE;
                    end else begin
                        r_idx_d = r_idx_inc;
                        r_cnt_d = r_cnt_q + 8'd1;
`ifdef AXI_SLV_BACKPRESSURE_EN
                        rvalid_d = 1'b0;
`else
                        rdata_d  = mem[r_idx_inc];
`endif
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        arready_d = (r_state_d == R_IDLE);
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state_q <= R_IDLE;
            r_idx_q   <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            arready_q <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            r_idx_q   <= r_idx_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            arready_q <= arready_d;
        end
    end

    assign s_axi.ARREADY = arready_q;
    assign s_axi.RDATA   = rdata_q;
    assign s_axi.RVALID  = rvalid_q;
    assign s_axi.RLAST   = rlast;
endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed bench for axi_slave_mem: write/read scoreboard with a reference word array.
module tb_axi_slave_mem;
    localparam int DW = 32;
    localparam int DP = 16;

    logic ACLK = 1'b0;
    logic ARESETn = 1'b0;
    always #5 ACLK = ~ACLK;

    axi_slave_mem_if #(.DATA_W(DW)) bus ();

    axi_slave_mem #(.DATA_W(DW), .DEPTH(DP), .TCO(1)) dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .s_axi   (bus)
    );

    int vectors = 0;
    int errs    = 0;
    logic [DW-1:0] model [DP];
    logic [DW:0]   rq [$];
    logic [1:0]    bq [$];
    int            w_idx;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        vectors++;
        errs++;
        $error("FAIL %s observed=no-handshake expected=handshake", tag);
    endtask

    task automatic aw_send(input int word, input int len, input logic [63:0] hi);
        int n = 0;
        bus.AWADDR  = hi | (64'(word) << 2);
        bus.AWLEN   = 8'(len);
        bus.AWVALID = 1'b1;
        while (!bus.AWREADY && n < 50) begin @(negedge ACLK); n++; end
        if (!bus.AWREADY) timeout_fail("aw_handshake");
        @(negedge ACLK);
        bus.AWVALID = 1'b0;
        w_idx = word % DP;
    endtask

    task automatic w_send(input logic [DW-1:0] d, input logic last);
        int n = 0;
        bus.WDATA  = d;
        bus.WLAST  = last;
        bus.WVALID = 1'b1;
        while (!bus.WREADY && n < 50) begin @(negedge ACLK); n++; end
        if (!bus.WREADY) timeout_fail("w_handshake");
        @(negedge ACLK);
        bus.WVALID = 1'b0;
        bus.WLAST  = 1'b0;
        model[w_idx] = d;
        w_idx = (w_idx + 1) % DP;
    endtask

    task automatic b_take(input string tag);
        int n = 0;
        logic [1:0] exp;
        bus.BREADY = 1'b1;
        while (!bus.BVALID && n < 50) begin @(negedge ACLK); n++; end
        if (!bus.BVALID) timeout_fail({tag, "_b"});
        exp = (bq.size() > 0) ? bq.pop_front() : 2'bxx;
        chk({tag, "_bresp"}, 64'(bus.BRESP), 64'(exp));
        @(negedge ACLK);
        bus.BREADY = 1'b0;
        chk({tag, "_bvalid_drop"}, 64'(bus.BVALID), 64'd0);
    endtask

    task automatic ar_send(input int word, input int len);
        int n = 0;
        for (int i = 0; i <= len; i++)
            rq.push_back({(i == len), model[(word + i) % DP]});
        bus.ARADDR  = 64'(word) << 2;
        bus.ARLEN   = 8'(len);
        bus.ARVALID = 1'b1;
        while (!bus.ARREADY && n < 50) begin @(negedge ACLK); n++; end
        if (!bus.ARREADY) timeout_fail("ar_handshake");
        @(negedge ACLK);
        bus.ARVALID = 1'b0;
        chk("ar_to_rvalid", 64'(bus.RVALID), 64'd1);
    endtask

    task automatic r_take(input int beats, input string tag);
        logic [DW:0] exp;
        bus.RREADY = 1'b1;
        for (int b = 0; b < beats; b++) begin
            int n = 0;
            while (!bus.RVALID && n < 50) begin @(negedge ACLK); n++; end
            if (!bus.RVALID) timeout_fail({tag, "_rvalid"});
            exp = (rq.size() > 0) ? rq.pop_front() : 'x;
            chk({tag, "_rdata"}, 64'(bus.RDATA), 64'(exp[DW-1:0]));
            chk({tag, "_rlast"}, 64'(bus.RLAST), 64'(exp[DW]));
            @(negedge ACLK);
        end
        bus.RREADY = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_awready"}, 64'(bus.AWREADY), 64'd0);
        chk({tag, "_wready"},  64'(bus.WREADY),  64'd0);
        chk({tag, "_bvalid"},  64'(bus.BVALID),  64'd0);
        chk({tag, "_bresp"},   64'(bus.BRESP),   64'd0);
        chk({tag, "_arready"}, 64'(bus.ARREADY), 64'd0);
        chk({tag, "_rvalid"},  64'(bus.RVALID),  64'd0);
        chk({tag, "_rlast"},   64'(bus.RLAST),   64'd0);
        chk({tag, "_rdata"},   64'(bus.RDATA),   64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=still-running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.AWADDR = '0; bus.AWLEN = '0; bus.AWVALID = 1'b0;
        bus.WDATA = '0; bus.WLAST = 1'b0; bus.WVALID = 1'b0; bus.BREADY = 1'b0;
        bus.ARADDR = '0; bus.ARLEN = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;

        // Reset state and ready rise one edge after release
        repeat (3) @(negedge ACLK);
        chk_reset_outputs("rst");
        ARESETn = 1'b1;
        @(negedge ACLK);
        chk("rel_awready", 64'(bus.AWREADY), 64'd1);
        chk("rel_arready", 64'(bus.ARREADY), 64'd1);

        // Single write then read
        aw_send(0, 0, 64'd0);
        bq.push_back(2'b00);
        w_send(32'd5, 1'b1);
        chk("single_bvalid_lat", 64'(bus.BVALID), 64'd1);
        b_take("single");
        ar_send(0, 0);
        r_take(1, "single");

        // Four-beat burst at word 4, upper address bits ignored
        aw_send(4, 3, 64'hA5C0_0000_0000_0000);
        bq.push_back(2'b00);
        for (int i = 1; i <= 4; i++) w_send(DW'(i), i == 4);
        chk("burst_bvalid_lat", 64'(bus.BVALID), 64'd1);
        b_take("burst");
        ar_send(4, 3);
        r_take(4, "burst");

        // Wrap past top of memory
        aw_send(14, 3, 64'd0);
        bq.push_back(2'b00);
        w_send(32'hA, 1'b0); w_send(32'hB, 1'b0); w_send(32'hC, 1'b0); w_send(32'hD, 1'b1);
        b_take("wrap");
        ar_send(0, 1);
        r_take(2, "wrap");

        // Early WLAST gives SLVERR; BREADY held low for 4 cycles
        aw_send(8, 3, 64'd0);
        bq.push_back(2'b10);
        w_send(32'h81, 1'b0);
        w_send(32'h82, 1'b1);
        chk("early_bvalid_lat", 64'(bus.BVALID), 64'd1);
        for (int i = 0; i < 4; i++) begin
            chk("bhold_bvalid", 64'(bus.BVALID), 64'd1);
            chk("bhold_bresp",  64'(bus.BRESP),  64'h2);
            @(negedge ACLK);
        end
        b_take("early");
        aw_send(10, 1, 64'd0);
        bq.push_back(2'b00);
        w_send(32'h91, 1'b0);
        w_send(32'h92, 1'b1);
        b_take("recover");
        ar_send(8, 3);
        r_take(4, "early");

        // RREADY low for 3 cycles on the first beat of a 3-beat read
        ar_send(4, 2);
        for (int i = 0; i < 3; i++) begin
            chk("rhold_rvalid", 64'(bus.RVALID), 64'd1);
            chk("rhold_rdata",  64'(bus.RDATA),  64'(model[4]));
            chk("rhold_rlast",  64'(bus.RLAST),  64'd0);
            @(negedge ACLK);
        end
        r_take(3, "rhold");

        // Reset after 2 of 4 beats
        aw_send(8, 3, 64'd0);
        w_send(32'hE1, 1'b0);
        w_send(32'hE2, 1'b0);
        bus.WDATA = 32'hE3; bus.WVALID = 1'b1;
        #2 ARESETn = 1'b0;
        #1 chk_reset_outputs("midrst");
        bus.WVALID = 1'b0;
        @(negedge ACLK);
        ARESETn = 1'b1;
        @(negedge ACLK);
        chk("midrst_awready", 64'(bus.AWREADY), 64'd1);
        aw_send(2, 0, 64'd0);
        bq.push_back(2'b00);
        w_send(32'h77, 1'b1);
        b_take("post_rst");
        ar_send(8, 1);
        r_take(2, "post_rst");
        ar_send(2, 0);
        r_take(1, "post_rst_new");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
